i2s_audio_out: RTL and testbench
================================

Name: i2s_audio_out

Overview:
- Stereo I2S transmitter between the guest core's parallel PCM audio outputs and the board's external audio DAC pins on the Poseidon top level. The guest core's sigma-delta AUDIO_L/AUDIO_R outputs are left unused on this board.
- Holds the latest left/right sample pair and serialises it as 16-bit Philips-format I2S, 32 BCLK slots per channel.
- Generates MCLK, BCLK and LRCLK from the single system clock, and handshakes each frame with the producer.

Parameters:
- BCLK_HALF, 8: clk cycles per BCLK half-period. At 50 MHz: BCLK 3.125 MHz, fs 48.83 kHz. Legal range ≥2.
- MCLK_HALF, 2: clk cycles per MCLK half-period. At 50 MHz: 12.5 MHz, 256·fs. Legal range ≥1.
- SIGNED_IN, 1: 1 = inputs are two's complement; 0 = inputs are offset-binary and are converted by inverting bit 15 at capture.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- reset_n, input, 1: synchronous reset, active-low.
- left_in, input, 16: left PCM sample.
- right_in, input, 16: right PCM sample.
- sample_valid, input, 1: one-cycle strobe that captures left_in/right_in into the hold registers.
- sample_req, output, 1: one-cycle pulse when a frame loads the hold registers; the producer should supply the next pair.
- overrun, output, 1: sticky flag; set when a sample pair is lost.
- i2s_mclk, output, 1: DAC master clock.
- i2s_bclk, output, 1: bit clock.
- i2s_lrclk, output, 1: word select; 0 = left, 1 = right.
- i2s_sdata, output, 1: serial data, MSB first.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs, counters and registers take their reset values.
  - Reset values: mclk=0, bclk=0, lrclk=1, sdata=0, sample_req=0, overrun=0.
  - Hold registers and shift register = 0.
  - Slot counter = 62, BCLK phase counter = 0, MCLK counter = 0.
  - Reset asserted mid-frame abandons the frame immediately; no partial data is output afterwards.
- MCLK: a counter runs 0..MCLK_HALF-1. i2s_mclk toggles on the cycle the counter wraps, so its period is 2·MCLK_HALF clk. It runs free and is not phase-aligned to BCLK.
- BCLK: a phase counter p runs 0..BCLK_HALF-1. i2s_bclk toggles when p = BCLK_HALF-1.
  - First rising edge: the BCLK_HALF-th cycle after reset release.
  - First falling edge: the 2·BCLK_HALF-th cycle after reset release.
- Falling-edge update: on each BCLK 1→0 toggle cycle, in that same registered cycle:
  - Slot s advances modulo 64.
  - i2s_lrclk = 1 when s is 31..62, else 0. This places the transition one BCLK before the MSB.
  - i2s_sdata: left[15-s] for s = 0..15, right[47-s] for s = 32..47, otherwise 0.
- Rising edges change nothing except i2s_bclk; the DAC samples on the BCLK rising edge.
- Frame load: on the falling edge entering s = 63:
  - The shift registers load from the hold registers.
  - sample_req = 1 for exactly that clk cycle.
  - The first load occurs on the first falling edge after reset (62→63).
  - The frame carrying the first-loaded pair is s = 0..62; left MSB at s = 0, right MSB at s = 32.
- Hold registers:
  - Capture on sample_valid, after the SIGNED_IN conversion.
  - If no sample_valid arrives between loads, the previous pair is replayed; this is not an error.
- Simultaneous sample_valid and load in the same cycle: the load uses the pre-capture hold value, and the new pair goes out in the next frame.
- Overrun: set when sample_valid occurs while the hold registers hold a pair captured since the last load that has not yet been loaded. The newer pair overwrites the older one. Cleared only by reset.
- Latency: a pair captured at cycle t appears at the first s = 63 load after t. The left MSB is on sdata at the falling edge one BCLK after that load.

Test Plan:
- Reset/clocking:
  - Stimulus: hold reset_n low 5 cycles, release; defaults.
  - Required: all outputs at reset values while in reset.
  - Required: bclk rises at cycle 8 and falls at cycle 16 after release.
  - Required: lrclk falls and sample_req pulses 1 cycle at cycle 16; mclk period 4 clk.
- Data serialisation:
  - Stimulus: left=0xA5C3, right=0x1234 via sample_valid before the 2nd load.
  - Required: in the following frame, sdata at slots 0..15 = A5C3 MSB-first and slots 32..47 = 1234 MSB-first.
  - Required: all other slots 0; lrclk high in slots 31..62.
- Replay:
  - Stimulus: no further sample_valid for 3 frames.
  - Required: identical bitstream each frame; overrun stays 0.
- Overrun:
  - Stimulus: two sample_valid pulses (0x1111/0x2222 then 0x3333/0x4444) within one frame.
  - Required: overrun = 1 and remains 1; next frame carries 0x3333/0x4444.
- Coincident capture:
  - Stimulus: sample_valid with 0x7FFF/0x8000 in the same cycle as sample_req.
  - Required: that frame carries the old pair; the next frame carries 0x7FFF/0x8000; no overrun.
- Unsigned mode and mid-frame reset:
  - Stimulus: SIGNED_IN=0, input 0x0000.
  - Required: 0x8000 is serialised.
  - Stimulus: reset_n low at slot 40 for 1 cycle.
  - Required: outputs return to reset values on the next cycle, and the first post-reset frame has no stale right-channel bits.

Source files
------------

// File: rtl/i2s_audio_out_if.sv
// PCM sample handshake between the guest core (producer) and the I2S transmitter.
// sample_valid strobes a new left/right pair; sample_req pulses when a frame consumes the held pair.
interface i2s_audio_out_if;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        sample_valid;
  logic        sample_req;
  logic        overrun;

  modport master (
    output left_in, right_in, sample_valid,
    input  sample_req, overrun
  );

  modport slave (
    input  left_in, right_in, sample_valid,
    output sample_req, overrun
  );
endinterface

// File: rtl/i2s_audio_out.sv
// Stereo 16-bit Philips I2S transmitter, 32 BCLK slots per channel, with MCLK/BCLK/LRCLK
// derived from the system clock and a hold-register handshake toward the PCM producer.
module i2s_audio_out #(
  parameter int BCLK_HALF = 8,
  parameter int MCLK_HALF = 2,
  parameter int SIGNED_IN = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  i2s_audio_out_if.slave pcm,
  output logic           i2s_mclk,
  output logic           i2s_bclk,
  output logic           i2s_lrclk,
  output logic           i2s_sdata
);

  localparam int PW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(BCLK_HALF - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MCLK_HALF - 1);

  logic [MW-1:0] r_mclk_cnt;
  logic          r_mclk;
  logic [PW-1:0] r_phase;
  logic          r_bclk;
  logic [5:0]    r_slot;
  logic          r_lrclk;
  logic          r_sdata;
  logic          r_sample_req;
  logic          r_overrun;
  logic          r_pending;
  logic [15:0]   r_hold_l;
  logic [15:0]   r_hold_r;
  logic [15:0]   r_frame_l;
  logic [15:0]   r_frame_r;

  logic          w_fall;
  logic [5:0]    w_slot_nxt;
  logic          w_load;
  logic          w_lr_nxt;
  logic          w_sd_nxt;
  logic [3:0]    w_bit_idx;
  logic [15:0]   w_left_cv;
  logic [15:0]   w_right_cv;

  // Offset-binary inputs become two's complement by flipping the MSB at capture.
  always_comb begin
    w_left_cv  = pcm.left_in;
    w_right_cv = pcm.right_in;
    if (SIGNED_IN == 0) begin
      w_left_cv[15]  = ~pcm.left_in[15];
      w_right_cv[15] = ~pcm.right_in[15];
    end
  end

  // Everything serial happens on the BCLK 1->0 toggle; slot is the one being entered.
  always_comb begin
    w_fall     = (r_phase == P_LAST) && r_bclk;
    w_slot_nxt = r_slot + 6'd1;
    w_load     = w_fall && (w_slot_nxt == 6'd63);
    w_lr_nxt   = (w_slot_nxt >= 6'd31) && (w_slot_nxt <= 6'd62);
    // Slots 0..15 and 32..47 both map to bit 15-(slot mod 16).
    w_bit_idx  = ~w_slot_nxt[3:0];
    w_sd_nxt   = 1'b0;
    case (w_slot_nxt[5:4])
      2'b00:   w_sd_nxt = r_frame_l[w_bit_idx];
      2'b10:   w_sd_nxt = r_frame_r[w_bit_idx];
      default: w_sd_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mclk_cnt   <= '0;
      r_mclk       <= 1'b0;
      r_phase      <= '0;
      r_bclk       <= 1'b0;
      r_slot       <= 6'd62;
      r_lrclk      <= 1'b1;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
      r_overrun    <= 1'b0;
      r_pending    <= 1'b0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_frame_l    <= '0;
      r_frame_r    <= '0;
    end else begin
      if (r_mclk_cnt == M_LAST) begin
        r_mclk_cnt <= '0;
        r_mclk     <= ~r_mclk;
      end else begin
        r_mclk_cnt <= r_mclk_cnt + 1'b1;
      end

      if (r_phase == P_LAST) begin
        r_phase <= '0;
        r_bclk  <= ~r_bclk;
      end else begin
        r_phase <= r_phase + 1'b1;
      end

      if (w_fall) begin
        r_slot  <= w_slot_nxt;
        r_lrclk <= w_lr_nxt;
        r_sdata <= w_sd_nxt;
      end

      r_sample_req <= w_load;

      // Load sees the pre-capture hold value, so a coincident capture waits for the next frame.
      if (w_load) begin
        r_frame_l <= r_hold_l;
        r_frame_r <= r_hold_r;
      end

      if (pcm.sample_valid) begin
        r_hold_l <= w_left_cv;
        r_hold_r <= w_right_cv;
      end

      if (w_load)
        r_pending <= pcm.sample_valid;
      else if (pcm.sample_valid)
        r_pending <= 1'b1;

      if (pcm.sample_valid && r_pending && !w_load)
        r_overrun <= 1'b1;
    end
  end

  assign i2s_mclk       = r_mclk;
  assign i2s_bclk       = r_bclk;
  assign i2s_lrclk      = r_lrclk;
  assign i2s_sdata      = r_sdata;
  assign pcm.sample_req = r_sample_req;
  assign pcm.overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_audio_out.sv
// Directed bench for i2s_audio_out: a signed-input and an unsigned-input instance share clock and reset.
module tb_i2s_audio_out;

  localparam int BH = 8;
  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

  logic clk;
  logic reset_n;
  logic mclk_s, bclk_s, lrclk_s, sdata_s;
  logic mclk_u, bclk_u, lrclk_u, sdata_u;

  int total;
  int bad;

  logic [63:0] cap_ds, cap_lr, cap_du, cap_lru;

  i2s_audio_out_if pcm_s();
  i2s_audio_out_if pcm_u();

  i2s_audio_out #(.BCLK_HALF(BH), .MCLK_HALF(2), .SIGNED_IN(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .pcm(pcm_s),
    .i2s_mclk(mclk_s), .i2s_bclk(bclk_s), .i2s_lrclk(lrclk_s), .i2s_sdata(sdata_s)
  );

  i2s_audio_out #(.BCLK_HALF(BH), .MCLK_HALF(2), .SIGNED_IN(0)) dut_u (
    .clk(clk), .reset_n(reset_n), .pcm(pcm_u),
    .i2s_mclk(mclk_u), .i2s_bclk(bclk_u), .i2s_lrclk(lrclk_u), .i2s_sdata(sdata_u)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_s(input logic [15:0] l, input logic [15:0] r);
    pcm_s.left_in      = l;
    pcm_s.right_in     = r;
    pcm_s.sample_valid = 1'b1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (!pcm_s.sample_req && n < 3000);
    total++;
    if (!pcm_s.sample_req) begin
      bad++;
      $display("FAIL wait_req: sample_req=%0b after %0d cycles, required 1", pcm_s.sample_req, n);
    end
  endtask

  // Starts on a load cycle; samples each falling-edge update, ends on the next load cycle.
  task automatic capture_frame;
    for (int s = 0; s < 64; s++) begin
      repeat (2 * BH) tick;
      cap_ds[63-s]  = sdata_s;
      cap_lr[63-s]  = lrclk_s;
      cap_du[63-s]  = sdata_u;
      cap_lru[63-s] = lrclk_u;
    end
    total++;
    if (pcm_s.sample_req !== 1'b1) begin
      bad++;
      $display("FAIL frame_end_req: sample_req=%0b, required 1", pcm_s.sample_req);
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] l, input logic [15:0] r);
    logic [63:0] exp_d;
    exp_d = {l, 16'h0000, r, 16'h0000};
    total++;
    if (cap_ds !== exp_d) begin
      bad++;
      $display("FAIL %s sdata: got %h, required %h", name, cap_ds, exp_d);
    end
    total++;
    if (cap_lr !== LR_EXP) begin
      bad++;
      $display("FAIL %s lrclk: got %h, required %h", name, cap_lr, LR_EXP);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (5) tick;
    total++;
    if ({mclk_s, bclk_s, lrclk_s, sdata_s, pcm_s.sample_req, pcm_s.overrun} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_s: got %b, required 001000",
               {mclk_s, bclk_s, lrclk_s, sdata_s, pcm_s.sample_req, pcm_s.overrun});
    end
    total++;
    if ({mclk_u, bclk_u, lrclk_u, sdata_u, pcm_u.sample_req, pcm_u.overrun} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_u: got %b, required 001000",
               {mclk_u, bclk_u, lrclk_u, sdata_u, pcm_u.sample_req, pcm_u.overrun});
    end
    reset_n = 1'b1;
    begin
      logic [7:0] mv;
      mv = '0;
      for (int k = 1; k <= 17; k++) begin
        tick;
        if (k <= 8) mv[k-1] = mclk_s;
        if (k == 7) begin
          total++;
          if (bclk_s !== 1'b0) begin bad++; $display("FAIL bclk_k7: got %b, required 0", bclk_s); end
        end
        if (k == 8) begin
          total++;
          if (bclk_s !== 1'b1) begin bad++; $display("FAIL bclk_rise_k8: got %b, required 1", bclk_s); end
        end
        if (k == 15) begin
          total++;
          if ({bclk_s, lrclk_s, pcm_s.sample_req} !== 3'b110) begin
            bad++;
            $display("FAIL k15 bclk/lr/req: got %b, required 110", {bclk_s, lrclk_s, pcm_s.sample_req});
          end
        end
        if (k == 16) begin
          total++;
          if ({bclk_s, lrclk_s, pcm_s.sample_req} !== 3'b001) begin
            bad++;
            $display("FAIL k16 bclk/lr/req: got %b, required 001", {bclk_s, lrclk_s, pcm_s.sample_req});
          end
        end
        if (k == 17) begin
          total++;
          if (pcm_s.sample_req !== 1'b0) begin bad++; $display("FAIL req_k17: got %b, required 0", pcm_s.sample_req); end
        end
      end
      total++;
      if (mv !== 8'b0110_0110) begin
        bad++;
        $display("FAIL mclk_pattern: got %b, required 01100110", mv);
      end
    end
  endtask

  task automatic test_serial;
    int n;
    drive_s(16'hA5C3, 16'h1234);
    pcm_u.left_in      = 16'h0000;
    pcm_u.right_in     = 16'h0000;
    pcm_u.sample_valid = 1'b1;
    tick;
    pcm_s.sample_valid = 1'b0;
    pcm_u.sample_valid = 1'b0;
    wait_req(n);
    capture_frame;
    check_frame("serial", 16'hA5C3, 16'h1234);
    total++;
    if (cap_du !== {16'h8000, 16'h0000, 16'h8000, 16'h0000}) begin
      bad++;
      $display("FAIL unsigned sdata: got %h, required 8000000080000000", cap_du);
    end
    total++;
    if (cap_lru !== LR_EXP) begin
      bad++;
      $display("FAIL unsigned lrclk: got %h, required %h", cap_lru, LR_EXP);
    end
  endtask

  task automatic test_replay;
    for (int f = 0; f < 3; f++) begin
      capture_frame;
      check_frame("replay", 16'hA5C3, 16'h1234);
      total++;
      if ({pcm_s.overrun, pcm_u.overrun} !== 2'b00) begin
        bad++;
        $display("FAIL replay overrun: got %b, required 00", {pcm_s.overrun, pcm_u.overrun});
      end
    end
  endtask

  task automatic test_coincident;
    repeat (64 * 2 * BH - 1) tick;
    drive_s(16'h7FFF, 16'h8000);
    tick;
    pcm_s.sample_valid = 1'b0;
    total++;
    if (pcm_s.sample_req !== 1'b1) begin
      bad++;
      $display("FAIL coincident req: got %b, required 1", pcm_s.sample_req);
    end
    capture_frame;
    check_frame("coincident_old", 16'hA5C3, 16'h1234);
    capture_frame;
    check_frame("coincident_new", 16'h7FFF, 16'h8000);
    total++;
    if (pcm_s.overrun !== 1'b0) begin
      bad++;
      $display("FAIL coincident overrun: got %b, required 0", pcm_s.overrun);
    end
  endtask

  task automatic test_overrun;
    int n;
    drive_s(16'h1111, 16'h2222);
    tick;
    pcm_s.sample_valid = 1'b0;
    tick;
    total++;
    if (pcm_s.overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_early: got %b, required 0", pcm_s.overrun);
    end
    drive_s(16'h3333, 16'h4444);
    tick;
    pcm_s.sample_valid = 1'b0;
    total++;
    if (pcm_s.overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %b, required 1", pcm_s.overrun);
    end
    wait_req(n);
    capture_frame;
    check_frame("overrun", 16'h3333, 16'h4444);
    total++;
    if (pcm_s.overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b, required 1", pcm_s.overrun);
    end
  endtask

  task automatic test_midframe_reset;
    int n;
    repeat (41 * 2 * BH + BH) tick;
    total++;
    if ({bclk_s, lrclk_s} !== 2'b11) begin
      bad++;
      $display("FAIL slot40 bclk/lr: got %b, required 11", {bclk_s, lrclk_s});
    end
    reset_n = 1'b0;
    tick;
    total++;
    if ({mclk_s, bclk_s, lrclk_s, sdata_s, pcm_s.sample_req, pcm_s.overrun} !== 6'b001000) begin
      bad++;
      $display("FAIL midreset_s: got %b, required 001000",
               {mclk_s, bclk_s, lrclk_s, sdata_s, pcm_s.sample_req, pcm_s.overrun});
    end
    reset_n = 1'b1;
    wait_req(n);
    total++;
    if (n !== 2 * BH) begin
      bad++;
      $display("FAIL midreset first_load: got %0d cycles, required %0d", n, 2 * BH);
    end
    capture_frame;
    check_frame("post_reset", 16'h0000, 16'h0000);
    total++;
    if (cap_du !== 64'h0) begin
      bad++;
      $display("FAIL post_reset unsigned sdata: got %h, required 0", cap_du);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    pcm_s.left_in = '0; pcm_s.right_in = '0; pcm_s.sample_valid = 1'b0;
    pcm_u.left_in = '0; pcm_u.right_in = '0; pcm_u.sample_valid = 1'b0;
    test_reset;
    test_serial;
    test_replay;
    test_coincident;
    test_overrun;
    test_midframe_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
